// File: rtl/questao_4_decoder.sv
// Receive-side decoder for question-4 match codes: a 3-entry loadable table,
// a single registered result slot with backpressure, and a saturating miss counter.
module questao_4_decoder #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [1:0]       wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             code_valid,
   output logic             code_ready,
   input  logic [1:0]       code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_hit,
   output logic [2:0]       out_onehot,
   output logic [CNT_W-1:0] miss_count
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t                    state_reg, state_next;
   logic [2:0][WIDTH-1:0]     entry_q;
   logic                      accept;
   logic [WIDTH-1:0]          data_next;
   logic                      hit_next;
   logic [2:0]                onehot_next;
   logic [WIDTH-1:0]          out_data_reg;
   logic                      out_hit_reg;
   logic [2:0]                out_onehot_reg;
   logic [CNT_W-1:0]          miss_reg;

   // Entry gi holds B(gi+1) and is selected by wr_sel == gi+1.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_entry
         logic [WIDTH-1:0] entry_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               entry_reg <= '0;
            end else if (wr_en && (wr_sel == 2'(gi + 1))) begin
               entry_reg <= wr_data;
            end
         end

         assign entry_q[gi] = entry_reg;
      end
   endgenerate

   assign code_ready = (state_reg == EMPTY) || out_ready;
   assign accept     = code_valid && code_ready;

   // Reads the registered table, so a same-cycle write is seen only by later codes.
   always_comb begin
      data_next   = '0;
      hit_next    = 1'b0;
      onehot_next = 3'b000;
      case (code)
         2'b01: begin
            data_next   = entry_q[0];
            hit_next    = 1'b1;
            onehot_next = 3'b001;
         end
         2'b10: begin
            data_next   = entry_q[1];
            hit_next    = 1'b1;
            onehot_next = 3'b010;
         end
         2'b11: begin
            data_next   = entry_q[2];
            hit_next    = 1'b1;
            onehot_next = 3'b100;
         end
         default: begin
            data_next   = '0;
            hit_next    = 1'b0;
            onehot_next = 3'b000;
         end
      endcase
   end

   always_comb begin
      state_next = state_reg;
      if (accept) begin
         state_next = FULL;
      end else if (out_ready) begin
         state_next = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   // Payload is only reloaded on accept; a drain leaves the last result in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_reg   <= '0;
         out_hit_reg    <= 1'b0;
         out_onehot_reg <= 3'b000;
      end else if (accept) begin
         out_data_reg   <= data_next;
         out_hit_reg    <= hit_next;
         out_onehot_reg <= onehot_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         miss_reg <= '0;
      end else if (accept && (code == 2'b00) && (miss_reg != {CNT_W{1'b1}})) begin
         miss_reg <= miss_reg + CNT_W'(1);
      end
   end

   assign out_valid  = (state_reg == FULL);
   assign out_data   = out_data_reg;
   assign out_hit    = out_hit_reg;
   assign out_onehot = out_onehot_reg;
   assign miss_count = miss_reg;

endmodule

// File: tb/tb_questao_4_decoder.sv
// Bench for questao_4_decoder: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_questao_4_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [1:0] wr_sel = 2'b00;
   logic       wr_data = 1'b0;
   logic       code_valid = 1'b0;
   logic [1:0] code = 2'b00;
   logic       out_ready = 1'b0;

   logic       code_ready, out_valid, out_data, out_hit;
   logic [2:0] out_onehot;
   logic [7:0] miss_count;
   logic       code_ready2, out_valid2, out_data2, out_hit2;
   logic [2:0] out_onehot2;
   logic [1:0] miss_count2;

   int n_vec = 0;
   int n_err = 0;
   bit cmp_on = 1'b0;

   questao_4_decoder #(.WIDTH(1), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .code_valid(code_valid), .code_ready(code_ready), .code(code),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_hit(out_hit), .out_onehot(out_onehot), .miss_count(miss_count)
   );

   questao_4_decoder #(.WIDTH(1), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .code_valid(code_valid), .code_ready(code_ready2), .code(code),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .out_hit(out_hit2), .out_onehot(out_onehot2), .miss_count(miss_count2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one result slot, a table indexed by code, two miss counters.
   bit m_valid, m_acc;
   int m_data, m_hit, m_oh, m_miss8, m_miss2;
   int tbl [4];

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 0; m_data = 0; m_hit = 0; m_oh = 0; m_miss8 = 0; m_miss2 = 0;
         for (int i = 0; i < 4; i++) tbl[i] = 0;
      end else begin
         m_acc = code_valid && (!m_valid || out_ready);
         if (m_acc) begin
            m_valid = 1;
            if (code == 2'b00) begin
               m_data = 0; m_hit = 0; m_oh = 0;
               if (m_miss8 < 255) m_miss8++;
               if (m_miss2 < 3) m_miss2++;
            end else begin
               m_data = tbl[code]; m_hit = 1; m_oh = 1 << (int'(code) - 1);
            end
         end else if (out_ready) begin
            m_valid = 0;
         end
         if (wr_en && wr_sel != 2'b00) tbl[wr_sel] = int'(wr_data);
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("valid", out_valid, m_valid);
         chk("ready", code_ready, (!m_valid || out_ready) ? 1 : 0);
         chk("data", out_data, m_data);
         chk("hit", out_hit, m_hit);
         chk("onehot", out_onehot, m_oh);
         chk("miss8", miss_count, m_miss8);
         chk("valid2", out_valid2, m_valid);
         chk("data2", out_data2, m_data);
         chk("onehot2", out_onehot2, m_oh);
         chk("miss2", miss_count2, m_miss2);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      cyc(); cyc();
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", code_ready, 1);
      chk("rst_data", out_data, 0);
      chk("rst_onehot", out_onehot, 0);
      chk("rst_miss", miss_count, 0);
      rst = 0;
      cmp_on = 1;

      // Table B1=1, B2=0, B3=1
      wr_en = 1; wr_sel = 2'b01; wr_data = 1; cyc();
      wr_sel = 2'b10; wr_data = 0; cyc();
      wr_sel = 2'b11; wr_data = 1; cyc();
      wr_en = 0; wr_sel = 2'b00;

      code_valid = 1; code = 2'b10; out_ready = 1; cyc();
      code_valid = 0;
      chk("b2_valid", out_valid, 1);
      chk("b2_data", out_data, 0);
      chk("b2_hit", out_hit, 1);
      chk("b2_onehot", out_onehot, 3'b010);
      cyc();

      code_valid = 1; code = 2'b00;
      for (int i = 1; i <= 3; i++) begin
         cyc();
         chk("miss_valid", out_valid, 1);
         chk("miss_data", out_data, 0);
         chk("miss_hit", out_hit, 0);
         chk("miss_onehot", out_onehot, 0);
         chk("miss_cnt", miss_count, i);
      end
      code_valid = 0; cyc();

      // Backpressure: first code taken, second stalls for 5 cycles
      out_ready = 0; code_valid = 1; code = 2'b01; cyc();
      chk("bp_data", out_data, 1);
      chk("bp_onehot", out_onehot, 3'b001);
      code = 2'b11; #1;
      chk("bp_ready", code_ready, 0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("stall_valid", out_valid, 1);
         chk("stall_onehot", out_onehot, 3'b001);
      end
      out_ready = 1; #1;
      chk("bp_ready_up", code_ready, 1);
      cyc();
      code_valid = 0;
      chk("b3_data", out_data, 1);
      chk("b3_onehot", out_onehot, 3'b100);
      chk("b3_valid", out_valid, 1);
      cyc();

      // Same-cycle write of B1 and accept of code 01 sees the old entry
      code_valid = 1; code = 2'b01; wr_en = 1; wr_sel = 2'b01; wr_data = 0; cyc();
      wr_en = 0; wr_sel = 2'b00;
      chk("coll_old", out_data, 1);
      cyc();
      chk("coll_new", out_data, 0);
      code_valid = 0; cyc();

      // Reset while holding a stalled result
      out_ready = 0; code_valid = 1; code = 2'b00; cyc();
      code_valid = 0;
      chk("pre_rst_valid", out_valid, 1);
      rst = 1; cyc(); rst = 0;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", code_ready, 1);
      chk("mid_rst_miss", miss_count, 0);
      code_valid = 1; code = 2'b11; out_ready = 1; cyc();
      code_valid = 0;
      chk("clr_data", out_data, 0);
      chk("clr_onehot", out_onehot, 3'b100);
      cyc();

      // Narrow counter saturates at 3
      code_valid = 1; code = 2'b00;
      for (int i = 1; i <= 5; i++) begin
         cyc();
         chk("sat2", miss_count2, (i < 3) ? i : 3);
         chk("sat8", miss_count, i);
      end
      code_valid = 0; cyc();

      for (int k = 0; k < 3000; k++) begin
         rst        = ($urandom_range(0, 99) == 0);
         wr_en      = ($urandom_range(0, 3) == 0);
         wr_sel     = 2'($urandom_range(0, 3));
         wr_data    = 1'($urandom_range(0, 1));
         code_valid = ($urandom_range(0, 9) < 7);
         code       = 2'($urandom_range(0, 3));
         out_ready  = ($urandom_range(0, 9) < 6);
         cyc();
      end
      rst = 0; code_valid = 0; wr_en = 0; out_ready = 1;
      cyc(); cyc();
      cmp_on = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/questao_4_decoder.md
Name: questao_4_decoder

Overview:
- Receive-side inverse of the question-4 match encoder.
- Stores the three candidate values B1..B3 in a loadable table.
- Accepts 2-bit match codes over a valid/ready stream and returns the reconstructed value of A with hit/one-hot qualifiers.
- Holds one output register with backpressure and counts miss codes (00).

Parameters:
- WIDTH, 1, bit width of A and of each table entry B1..B3.
- CNT_W, 8, width of the saturating miss counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- wr_en  input  1  table write strobe
- wr_sel  input  2  entry select: 01=B1, 10=B2, 11=B3, 00=no write
- wr_data  input  WIDTH  value written to the selected entry
- code_valid  input  1  code present
- code_ready  output  1  decoder can accept a code this cycle
- code  input  2  match code: 01=B1, 10=B2, 11=B3, 00=no match
- out_valid  output  1  output register holds a result
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  reconstructed A (selected entry; 0 on miss)
- out_hit  output  1  1 when code != 00
- out_onehot  output  3  bit0=B1, bit1=B2, bit2=B3; 000 on miss
- miss_count  output  CNT_W  number of accepted 00 codes, saturating

Behaviour:
- Reset is synchronous and active-high. All state updates occur on the rising edge of clk; rst has priority over every other input.
- Reset values:
  - entries B1..B3 = 0
  - out_valid = 0, out_data = 0, out_hit = 0, out_onehot = 000
  - miss_count = 0
  - FSM state = EMPTY
- FSM states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- code_ready = (state==EMPTY) || out_ready. Combinational; does not depend on code_valid.
- Code accept: occurs when code_valid && code_ready.
  - out_* are loaded on that edge; latency is 1 cycle.
  - state becomes FULL.
- Drain: in FULL with out_ready=1 and no accept, state becomes EMPTY. out_data, out_hit and out_onehot retain their last values; consumers qualify them with out_valid.
- Simultaneous drain and accept in FULL: the new result replaces the old one in the same edge. State stays FULL. Full throughput is one code per cycle.
- FULL with out_ready=0: all out_* hold stable, code_ready=0, and no code is consumed.
- Decode rules:
  - 01 -> out_data=B1, onehot=001, hit=1
  - 10 -> out_data=B2, onehot=010, hit=1
  - 11 -> out_data=B3, onehot=100, hit=1
  - 00 -> out_data=0, onehot=000, hit=0
- Table write: on wr_en with wr_sel!=00, the selected entry takes wr_data at the edge. wr_sel=00 is ignored. Writes are accepted in any FSM state and do not touch the output register.
- Write/accept collision: if the accepted code selects the entry being written in the same cycle, out_data takes the OLD entry value. The new value applies from the next accepted code.
- Miss counter:
  - Increments by 1 on each accepted code 00.
  - Saturates at 2^CNT_W-1; it never wraps.
  - Not incremented by stalled codes (code_valid=1 with code_ready=0).
- Reset mid-operation: a pending result is discarded (out_valid=0 on the next cycle). The table and counter are cleared.
- No X propagation: every output is driven from a register or from the FSM state at all times after reset.

Test Plan:
- Reset then write B1=1, B2=0, B3=1 (WIDTH=1). Send code 10 with out_ready=1 -> one cycle later out_valid=1, out_data=0, out_hit=1, out_onehot=010.
- Send code 00 three times with out_ready=1 -> three results with out_data=0, out_hit=0, out_onehot=000; miss_count=3.
- Hold out_ready=0, send code 01 then present code 11 -> code_ready=0 after the first accept. out_data stays B1 for 5 stalled cycles. Raise out_ready -> 11 is accepted in the same edge, and the next result is B3 with onehot=100.
- Same cycle: wr_en=1, wr_sel=01, wr_data=0 (B1 was 1) and code 01 accepted -> out_data=1. A subsequent code 01 -> out_data=0.
- With CNT_W=2, accept 5 miss codes -> miss_count reads 1,2,3,3,3.
- Assert rst while FULL with out_ready=0 -> next cycle out_valid=0, code_ready=1, miss_count=0. Code 11 then returns out_data=0 (table cleared).
